// File: rtl/plot_pkg.sv
// Shared constants, state encoding and y scaling for the trace plotter.
// Imported by the plotter interface, buffer and top level.
package plot_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int S_W = 18;
    localparam int B_W = 2 * Y_W;

    localparam int Y_C1 = 120;
    localparam int Y_C2 = 360;
    localparam logic signed [S_W-1:0] LIM = 18'sd119;

    localparam logic [1:0] PIX_ERASE = 2'b00;
    localparam logic [1:0] PIX_T1    = 2'b10;
    localparam logic [1:0] PIX_T2    = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ER1,
        ER2,
        DR1,
        DR2
    } state_t;

    // Shift, clamp to +/-LIM, then flip around the band centre.
    function automatic logic [Y_W-1:0] scale_y(
        input logic signed [S_W-1:0] x,
        input int                    shift,
        input int                    centre
    );
        logic signed [S_W-1:0] s;
        s = x >>> shift;
        if (s > LIM)
            s = LIM;
        else if (s < -LIM)
            s = -LIM;
        return Y_W'(centre - int'(s));
    endfunction

endpackage

// File: rtl/trace_plotter_if.sv
// Sample handshake from the oscillator core plus the pixel-write port.
// master = sample source / pixel sink, slave = plotter.
interface trace_plotter_if;
    import plot_pkg::*;

    logic             sample_valid;
    logic             sample_ready;
    logic [S_W-1:0]   x1;
    logic [S_W-1:0]   x2;
    logic [X_W-1:0]   write_xCoord;
    logic [Y_W-1:0]   write_yCoord;
    logic             w_en;
    logic [1:0]       disp_bit;

    modport master (
        output sample_valid, x1, x2,
        input  sample_ready, write_xCoord, write_yCoord, w_en, disp_bit
    );

    modport slave (
        input  sample_valid, x1, x2,
        output sample_ready, write_xCoord, write_yCoord, w_en, disp_bit
    );

endinterface

// File: rtl/trace_line_buffer.sv
// Simple dual-port column memory holding the last {y1, y2} per column.
// Registered read so it maps onto block RAM.
module trace_line_buffer #(
    parameter int DEPTH = 640,
    parameter int W     = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trace_plotter.sv
// Decimates oscillator samples and plots two scrolling traces,
// erasing each column's previous pixels before drawing new ones.
module trace_plotter
    import plot_pkg::*;
#(
    parameter int VGA_WIDTH = 640,
    parameter int DECIM     = 1,
    parameter int Y_SHIFT   = 10
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    trace_plotter_if.slave  bus
);

    state_t         state;
    state_t         nstate;
    logic [X_W-1:0] col;
    logic [7:0]     dcnt;
    logic           swept;
    logic           run;
    logic [Y_W-1:0] y1_q;
    logic [Y_W-1:0] y2_q;
    logic [B_W-1:0] old_q;
    logic [B_W-1:0] rdata;
    logic           ready;
    logic           accept;
    logic           plot;

    assign ready  = (state == IDLE) && run;
    assign accept = bus.sample_valid && ready;
    assign plot   = accept && (dcnt == 8'd0);

    assign bus.sample_ready = ready;

    // Read address is always col, so the accept edge launches the read.
    trace_line_buffer #(
        .DEPTH (VGA_WIDTH),
        .W     (B_W)
    ) u_buf (
        .clk   (CLOCK_50),
        .we    (state == DR2),
        .waddr (col),
        .wdata ({y1_q, y2_q}),
        .raddr (col),
        .rdata (rdata)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= IDLE;
            col   <= '0;
            dcnt  <= '0;
            swept <= 1'b0;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= nstate;
            if (accept)
                dcnt <= (dcnt == 8'(DECIM - 1)) ? 8'd0 : dcnt + 8'd1;
            if (plot) begin
                y1_q <= scale_y(bus.x1, Y_SHIFT, Y_C1);
                y2_q <= scale_y(bus.x2, Y_SHIFT, Y_C2);
            end
            if (state == READ)
                old_q <= rdata;
            if (state == DR2) begin
                if (col == X_W'(VGA_WIDTH - 1)) begin
                    col   <= '0;
                    swept <= 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nstate           = state;
        bus.write_xCoord = '0;
        bus.write_yCoord = '0;
        bus.w_en         = 1'b0;
        bus.disp_bit     = PIX_ERASE;
        unique case (state)
            IDLE: if (plot) nstate = READ;
            READ: nstate = ER1;
            ER1: begin
                nstate           = ER2;
                bus.write_xCoord = col;
                bus.write_yCoord = old_q[B_W-1:Y_W];
                bus.w_en         = swept;
            end
            ER2: begin
                nstate           = DR1;
                bus.write_xCoord = col;
                bus.write_yCoord = old_q[Y_W-1:0];
                bus.w_en         = swept;
            end
            DR1: begin
                nstate           = DR2;
                bus.write_xCoord = col;
                bus.write_yCoord = y1_q;
                bus.w_en         = 1'b1;
                bus.disp_bit     = PIX_T1;
            end
            DR2: begin
                nstate           = IDLE;
                bus.write_xCoord = col;
                bus.write_yCoord = y2_q;
                bus.w_en         = 1'b1;
                bus.disp_bit     = PIX_T2;
            end
            default: nstate = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trace_plotter.sv
// Scoreboard bench: two plotters (DECIM 1 and 4) against a
// column-memory reference model built from the pixel rules.
module tb_trace_plotter;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    trace_plotter_if ia ();
    trace_plotter_if ib ();

    trace_plotter #(
        .VGA_WIDTH (640),
        .DECIM     (1),
        .Y_SHIFT   (10)
    ) dut_a (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ia)
    );

    trace_plotter #(
        .VGA_WIDTH (640),
        .DECIM     (4),
        .Y_SHIFT   (10)
    ) dut_b (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ib)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t qa[$];
    pix_t qb[$];

    int checks   = 0;
    int failures = 0;

    int m_col[2];
    int m_dcnt[2];
    int m_swept[2];
    int m_y1[2][640];
    int m_y2[2][640];
    int decim[2] = '{1, 4};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Floor division by 2^10, clamp, offset from the band centre.
    function automatic int band(input logic [17:0] x, input int centre);
        int v;
        int s;
        v = int'($signed(x));
        s = (v >= 0) ? v / 1024 : -((-v + 1023) / 1024);
        if (s > 119) s = 119;
        if (s < -119) s = -119;
        return centre - s;
    endfunction

    task automatic push(input int d, input int x, input int y, input int c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        if (d == 0) qa.push_back(p);
        else qb.push_back(p);
    endtask

    task automatic model_accept(input int d, input logic [17:0] a,
                                input logic [17:0] b, output bit pl);
        int c;
        int y1;
        int y2;
        pl = (m_dcnt[d] == 0);
        m_dcnt[d] = (m_dcnt[d] + 1) % decim[d];
        if (pl) begin
            c  = m_col[d];
            y1 = band(a, 120);
            y2 = band(b, 360);
            if (m_swept[d] != 0) begin
                push(d, c, m_y1[d][c], 0);
                push(d, c, m_y2[d][c], 0);
            end
            push(d, c, y1, 2);
            push(d, c, y2, 1);
            m_y1[d][c] = y1;
            m_y2[d][c] = y2;
            if (c == 639) begin
                m_col[d]   = 0;
                m_swept[d] = 1;
            end else begin
                m_col[d] = c + 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_col[d]   = 0;
            m_dcnt[d]  = 0;
            m_swept[d] = 0;
        end
        qa.delete();
        qb.delete();
    endtask

    function automatic bit rdy(input int d);
        return (d == 0) ? ia.sample_ready : ib.sample_ready;
    endfunction

    task automatic drive(input int d, input logic v,
                         input logic [17:0] a, input logic [17:0] b);
        if (d == 0) begin
            ia.sample_valid = v;
            ia.x1 = a;
            ia.x2 = b;
        end else begin
            ib.sample_valid = v;
            ib.x1 = a;
            ib.x2 = b;
        end
    endtask

    task automatic idle(input int n);
        drive(0, 1'b0, 18'($urandom), 18'($urandom));
        drive(1, 1'b0, 18'($urandom), 18'($urandom));
        repeat (n) begin
            @(negedge CLOCK_50);
            #1;
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input int d, input logic [17:0] a,
                        input logic [17:0] b, input bit tchk);
        int n;
        bit pl;
        n = 0;
        drive(d, 1'b1, a, b);
        while (!rdy(d) && n < 20) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=0 want=1");
            drive(d, 1'b0, a, b);
            return;
        end
        model_accept(d, a, b, pl);
        if (pl && tchk) begin
            for (int k = 1; k <= 6; k++) begin
                @(negedge CLOCK_50);
                #1;
                check("ready_seq", int'(rdy(d)), (k == 6) ? 1 : 0);
                if (k < 6)
                    drive(d, 1'b1, 18'($urandom), 18'($urandom));
            end
        end else begin
            @(negedge CLOCK_50);
            #1;
        end
    endtask

    always @(negedge CLOCK_50) begin
        pix_t p;
        if (ia.w_en === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_extra_pixel", 1, 0);
            end else begin
                p = qa.pop_front();
                check("a_x", int'(ia.write_xCoord), p.x);
                check("a_y", int'(ia.write_yCoord), p.y);
                check("a_colour", int'(ia.disp_bit), p.c);
            end
        end
        if (ib.w_en === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_extra_pixel", 1, 0);
            end else begin
                p = qb.pop_front();
                check("b_x", int'(ib.write_xCoord), p.x);
                check("b_y", int'(ib.write_yCoord), p.y);
                check("b_colour", int'(ib.disp_bit), p.c);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive(0, 1'b0, 18'd0, 18'd0);
        drive(1, 1'b0, 18'd0, 18'd0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #1;
        check("rst_w_en", int'(ia.w_en), 0);
        check("rst_x", int'(ia.write_xCoord), 0);
        check("rst_y", int'(ia.write_yCoord), 0);
        check("rst_disp", int'(ia.disp_bit), 0);
        check("rst_ready_a", int'(ia.sample_ready), 0);
        check("rst_ready_b", int'(ib.sample_ready), 0);
        reset = 1'b1;
        check("ready_at_release", int'(ia.sample_ready), 0);
        @(negedge CLOCK_50);
        #1;
        check("ready_after_release", int'(ia.sample_ready), 1);

        send(0, 18'h00000, 18'h00000, 1'b1);
        send(0, 18'h04000, 18'h3C000, 1'b1);
        send(0, 18'h1FFFF, 18'h20000, 1'b1);
        send(0, 18'h20000, 18'h1FFFF, 1'b1);

        // Enough plotted samples to wrap col and start erasing.
        for (int i = 0; i < 640; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
            send(0, 18'($urandom), 18'($urandom), 1'b1);
        end
        idle(2);

        // Reset arrives while dut_a sits in ER2.
        send(0, 18'($urandom), 18'($urandom), 1'b0);
        @(negedge CLOCK_50);
        #1;
        @(negedge CLOCK_50);
        #1;
        drive(0, 1'b0, 18'd0, 18'd0);
        reset = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        #1;
        check("midrst_w_en", int'(ia.w_en), 0);
        check("midrst_x", int'(ia.write_xCoord), 0);
        check("midrst_ready", int'(ia.sample_ready), 0);
        reset = 1'b1;
        check("midrst_ready_hold", int'(ia.sample_ready), 0);
        @(negedge CLOCK_50);
        #1;
        check("midrst_ready_back", int'(ia.sample_ready), 1);
        send(0, 18'h00000, 18'h00000, 1'b1);
        idle(1);

        for (int i = 0; i < 8; i++)
            send(1, 18'($urandom), 18'($urandom), 1'b1);
        idle(10);

        check("a_left", qa.size(), 0);
        check("b_left", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
